// File: rtl/xsleena_pkg.sv
// Shared definitions for the Xain'd Sleena ROM slot arbiter and its phase wheel:
// requester ids, the 8-phase slot-owner table and the read-tag type.
package xsleena_pkg;

  localparam logic [1:0] REQ_MAIN = 2'd0;
  localparam logic [1:0] REQ_SUB  = 2'd1;
  localparam logic [1:0] REQ_VID  = 2'd2;
  localparam logic [1:0] REQ_SND  = 2'd3;

  // Entry k (bits [2k+:2]) is the owner of wheel phase k; phase 0 is the LSB entry.
  localparam logic [15:0] SLOT_OWNER_TBL = {
    REQ_SND, REQ_SUB, REQ_VID, REQ_MAIN,
    REQ_SND, REQ_SUB, REQ_VID, REQ_MAIN
  };

  typedef struct packed {
    logic       valid;
    logic [1:0] id;
  } tag_t;

  function automatic logic [1:0] slot_owner(input logic [2:0] phase);
    return SLOT_OWNER_TBL[{phase, 1'b0} +: 2];
  endfunction

  function automatic logic [3:0] id_onehot(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/xsleena_slot_wheel.sv
// 8-phase slot wheel: phase counter, owner decode of the upcoming phase and the
// 12 MHz / HCLKn clock enables, all phase-locked to each other.
module xsleena_slot_wheel
  import xsleena_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [2:0] o_phase,
  output logic [1:0] o_next_owner,
  output logic       o_cen12,
  output logic       o_hclkn_cen
);

  logic [2:0] next_phase;

  assign next_phase   = o_phase + 3'd1;
  assign o_next_owner = slot_owner(next_phase);

  // Enables are decoded from the phase being entered so they line up with o_phase.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_phase     <= 3'd7;
      o_cen12     <= 1'b0;
      o_hclkn_cen <= 1'b0;
    end else begin
      o_phase     <= next_phase;
      o_cen12     <= (next_phase[1:0] == 2'd0);
      o_hclkn_cen <= (next_phase == 3'd1);
    end
  end

endmodule

// File: rtl/xsleena_rom_slot_arbiter.sv
// Time-slot arbiter sharing one memory read port among main, sub, video and sound.
// Optional feature: XSLEENA_SLOT_RECLAIM_EN hands idle slots to other requesters.
module xsleena_rom_slot_arbiter
  import xsleena_pkg::*;
#(
  parameter int AW  = 22,
  parameter int DW  = 16,
  parameter int LAT = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [3:0]      i_req,
  input  logic [4*AW-1:0] i_addr,
  output logic [3:0]      o_ack,
  output logic [3:0]      o_valid,
  output logic [DW-1:0]   o_data,
  output logic            o_mem_rd,
  output logic [AW-1:0]   o_mem_addr,
  input  logic [DW-1:0]   i_mem_data,
  output logic [2:0]      o_phase,
  output logic            o_cen12,
  output logic            o_hclkn_cen
);

  // Handshake: i_req[n] is a level held with a stable address until the
  // one-cycle o_ack[n] pulse; a requester acked this cycle is not eligible at
  // the next edge, and its data returns as one o_valid[n] pulse LAT+1 cycles later.

  logic [1:0] next_owner;
  logic [3:0] eligible;
  logic       grant;
  logic [1:0] grant_id;
  tag_t       tags [LAT+1];

  xsleena_slot_wheel u_wheel (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .o_phase      (o_phase),
    .o_next_owner (next_owner),
    .o_cen12      (o_cen12),
    .o_hclkn_cen  (o_hclkn_cen)
  );

  assign eligible = i_req & ~o_ack;

`ifdef XSLEENA_SLOT_RECLAIM_EN
  logic [1:0] rr_ptr;
  logic [1:0] cand;
  logic       reclaim;

  // Owner wins; otherwise search round-robin starting after the last reclaimer.
  always_comb begin
    grant    = 1'b0;
    grant_id = next_owner;
    reclaim  = 1'b0;
    cand     = rr_ptr;
    if (eligible[next_owner]) begin
      grant = 1'b1;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        cand = rr_ptr + 2'(k);
        if (!reclaim && eligible[cand]) begin
          reclaim  = 1'b1;
          grant    = 1'b1;
          grant_id = cand;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr <= 2'd0;
    end else if (reclaim) begin
      rr_ptr <= grant_id;
    end
  end
`else
  assign grant    = eligible[next_owner];
  assign grant_id = next_owner;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ack      <= 4'b0;
      o_mem_rd   <= 1'b0;
      o_mem_addr <= '0;
      o_valid    <= 4'b0;
      o_data     <= '0;
      for (int i = 0; i <= LAT; i++) begin
        tags[i] <= '0;
      end
    end else begin
      o_ack    <= grant ? id_onehot(grant_id) : 4'b0;
      o_mem_rd <= grant;
      if (grant) begin
        o_mem_addr <= i_addr[grant_id*AW +: AW];
      end
      // tags[k] describes the read issued k cycles ago; tags[LAT] meets its data.
      tags[0] <= {grant, grant_id};
      for (int i = 1; i <= LAT; i++) begin
        tags[i] <= tags[i-1];
      end
      o_valid <= tags[LAT].valid ? id_onehot(tags[LAT].id) : 4'b0;
      if (tags[LAT].valid) begin
        o_data <= i_mem_data;
      end
    end
  end

endmodule

// File: doc/xsleena_rom_slot_arbiter.md
# xsleena_rom_slot_arbiter

Time-slot arbiter sharing one 48 MHz ROM/SDRAM read port among four requesters: main CPU, sub CPU, video fetch and sound CPU. An internal 8-phase wheel grants each requester fixed slots and also drives the 12 MHz and HCLKn clock enables, so memory slots stay phase-locked to the CPU and pixel enables. It sits between the requesters and the memory controller.

## Interface
Parameters:
- AW, 22, address width per requester
- DW, 16, read data width
- LAT, 2, fixed memory read latency in cycles (1..4)

Ports:
- i_clk  in  1  48 MHz system clock
- i_rst  in  1  reset; synchronous and active-high
- i_req  in  4  per-requester read request, level; bit n = requester n
- i_addr  in  4*AW  requester n address in bits [n*AW +: AW]; held stable while i_req[n]=1
- o_ack  out  4  one-cycle grant pulse, one-hot or zero
- o_valid  out  4  one-cycle read-data-valid pulse, one-hot or zero
- o_data  out  DW  read data, qualified by o_valid
- o_mem_rd  out  1  memory read strobe, one cycle per access
- o_mem_addr  out  AW  memory address, qualified by o_mem_rd
- i_mem_data  in  DW  memory data, valid exactly LAT cycles after o_mem_rd
- o_phase  out  3  current wheel phase
- o_cen12  out  1  12 MHz enable
- o_hclkn_cen  out  1  HCLKn enable

## Operation
- Phase register: reset value 7; increments by 1 every cycle, modulo 8. The first cycle after reset release is phase 0.
- Fixed slot owners:
  - phases 0, 4: requester 0
  - phases 2, 6: requester 1
  - phases 1, 5: requester 2
  - phases 3, 7: requester 3
- Grant: on the edge entering phase k, if the owner's i_req is 1 and the owner is not excluded, the block registers all of the following, visible during phase k:
  - o_mem_rd=1
  - o_mem_addr = owner address
  - o_ack[owner]=1
- If no grant is made, o_mem_rd=0, o_ack=0 and o_mem_addr holds its previous value.
- Exclusion: a requester whose o_ack is 1 in the current cycle is ineligible at the next edge. This prevents a double issue before the requester drops or changes its request.
- Tag pipeline: a LAT+1 deep shift register carries {valid, 2-bit id} for each issued read.
- Return path: when the tag emerges, o_data <= i_mem_data and o_valid[id]=1 for one cycle. No other cycle asserts o_valid.
- Enables, registered and decoded from the next phase value:
  - o_cen12=1 during phases 0 and 4 (one pulse per 4 cycles)
  - o_hclkn_cen=1 during phase 1 only (one pulse per 8 cycles)
- Reset values: o_ack=0, o_valid=0, o_mem_rd=0, o_mem_addr=0, o_data=0, o_cen12=0, o_hclkn_cen=0, o_phase=7, all tags invalid.
- Reset mid-operation: in-flight reads are dropped with no o_valid; memory data still arriving is ignored.
- Requester dropping i_req in the same cycle it is acked: legal; the read still completes.

## Timing
- Grant latency: o_ack and o_mem_rd are asserted in the first owned phase at whose entering edge i_req was sampled 1. Worst-case wait is 4 cycles (8 with the exclusion rule).
- Data latency: o_valid in cycle t+LAT+1, where t is the o_ack cycle.
- Throughput: at most one read per cycle. Each requester is guaranteed 2 slots per 8 cycles, i.e. 12 Mreads/s.
- o_cen12 and o_hclkn_cen have a fixed relation to o_phase, independent of request traffic.

## Configuration
- XSLEENA_SLOT_RECLAIM_EN defined:
  - A slot whose owner is idle or excluded goes to another eligible requester.
  - Selection uses a 2-bit round-robin pointer that starts after the last reclaimer and is reset to 0.
  - Owned slots always win over reclaim.
- Undefined: idle slots produce no access; the schedule is strictly deterministic.

## Structure
- Shared package xsleena_pkg holds:
  - requester id constants: REQ_MAIN=0, REQ_SUB=1, REQ_VID=2, REQ_SND=3
  - the 8-entry slot-owner table
  - the tag struct type
- One natural sub-module: xsleena_slot_wheel, containing the phase counter, owner decode and enable generation. It is reused by the video timing block.

## Test plan
- Reset release, no requests -> o_phase steps 0,1,...,7,0. o_cen12 high in phases 0 and 4; o_hclkn_cen high in phase 1 only; o_mem_rd stays 0.
- i_req[0]=1 from reset, addr 0x000123, LAT=2 -> o_ack[0] and o_mem_rd in phase 0 with o_mem_addr=0x000123. o_valid[0] 3 cycles later, carrying the i_mem_data value presented 2 cycles after issue.
- All four i_req held high -> grant order 0,2,1,3,0,2,1,3, one per cycle. No requester is acked in two consecutive cycles.
- Only i_req[1]=1, macro undefined -> acks only in phases 2 and 6; o_mem_rd=0 in all other phases.
- Only i_req[1]=1, XSLEENA_SLOT_RECLAIM_EN defined -> requester 1 is acked every other cycle (exclusion rule), taking otherwise-idle slots.
- i_rst pulsed 1 cycle after an ack -> no o_valid for that read. o_phase=7 during reset, then 0.
